// File: rtl/bu2_nwc_butterfly.sv
// bu2_nwc_butterfly
//   Radix-2 Cooley-Tukey butterfly for NWC NTT datapaths with a runtime
//   modulus. Computes a = x + w*y mod q and b = x - w*y mod q.
//   Fully pipelined: one butterfly per clock, 2-cycle latency.
//   Twiddle and modulus are forwarded with matching delay so that
//   butterflies can be chained by the stage logic.
//
// Ports
//   clk             in   1        rising-edge clock
//   rst             in   1        asynchronous active-high reset
//   in1             in   D_WIDTH  upper operand x, x < modulus
//   in2             in   D_WIDTH  lower operand y, y < modulus
//   twiddle         in   D_WIDTH  twiddle factor w, w < modulus
//   modulus         in   D_WIDTH  modulus q, q >= 2
//   BU_a            out  D_WIDTH  (x + w*y) mod q
//   BU_b            out  D_WIDTH  (x - w*y) mod q
//   twiddle_BU_out  out  D_WIDTH  twiddle aligned with BU_a/BU_b
//   modulus_BU_out  out  D_WIDTH  modulus aligned with BU_a/BU_b
module bu2_nwc_butterfly #(
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] in1,
  input  logic [D_WIDTH-1:0] in2,
  input  logic [D_WIDTH-1:0] twiddle,
  input  logic [D_WIDTH-1:0] modulus,
  output logic [D_WIDTH-1:0] BU_a,
  output logic [D_WIDTH-1:0] BU_b,
  output logic [D_WIDTH-1:0] twiddle_BU_out,
  output logic [D_WIDTH-1:0] modulus_BU_out
);

  localparam int P_WIDTH = 2 * D_WIDTH;

  // stage 1 registers
  logic [D_WIDTH-1:0] x_s1;
  logic [D_WIDTH-1:0] t_s1;
  logic [D_WIDTH-1:0] w_s1;
  logic [D_WIDTH-1:0] q_s1;

  // stage 1 combinational: full-width product reduced mod q
  logic [P_WIDTH-1:0] prod;
  logic [D_WIDTH-1:0] t_next;

  always_comb begin
    prod   = P_WIDTH'(in2) * P_WIDTH'(twiddle);
    t_next = '0;
    // q = 0 is out of contract; force a defined result instead of a
    // divide-by-zero X.
    if (modulus != '0) begin
      t_next = D_WIDTH'(prod % P_WIDTH'(modulus));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_s1 <= '0;
      t_s1 <= '0;
      w_s1 <= '0;
      q_s1 <= '0;
    end else begin
      x_s1 <= in1;
      t_s1 <= t_next;
      w_s1 <= twiddle;
      q_s1 <= modulus;
    end
  end

  // stage 2 combinational: modular add / subtract with single correction
  logic [D_WIDTH:0]   sum;
  logic [D_WIDTH-1:0] a_next;
  logic [D_WIDTH-1:0] diff;
  logic [D_WIDTH-1:0] b_next;

  always_comb begin
    sum    = {1'b0, x_s1} + {1'b0, t_s1};
    a_next = D_WIDTH'(sum);
    if (sum >= {1'b0, q_s1}) begin
      a_next = D_WIDTH'(sum - {1'b0, q_s1});
    end
    // modular wrap of x - t is harmless: adding q brings the true value
    // back into [0, q) when x < t.
    diff   = x_s1 - t_s1;
    b_next = diff;
    if (x_s1 < t_s1) begin
      b_next = diff + q_s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      BU_a           <= '0;
      BU_b           <= '0;
      twiddle_BU_out <= '0;
      modulus_BU_out <= '0;
    end else begin
      BU_a           <= a_next;
      BU_b           <= b_next;
      twiddle_BU_out <= w_s1;
      modulus_BU_out <= q_s1;
    end
  end

endmodule

// File: tb/tb_bu2_nwc_butterfly.sv
// tb_bu2_nwc_butterfly
//   Directed and streaming checks of the NWC butterfly with q = 193.
//   Inputs change on the falling edge; outputs are sampled 1 ns after
//   the rising edge.
module tb_bu2_nwc_butterfly;

  localparam int DW = 32;
  localparam logic [DW-1:0] Q = 32'd193;

  logic          clk;
  logic          rst;
  logic [DW-1:0] in1;
  logic [DW-1:0] in2;
  logic [DW-1:0] twiddle;
  logic [DW-1:0] modulus;
  logic [DW-1:0] BU_a;
  logic [DW-1:0] BU_b;
  logic [DW-1:0] twiddle_BU_out;
  logic [DW-1:0] modulus_BU_out;

  int tests_run;
  int tests_failed;

  bu2_nwc_butterfly #(.D_WIDTH(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .in1            (in1),
    .in2            (in2),
    .twiddle        (twiddle),
    .modulus        (modulus),
    .BU_a           (BU_a),
    .BU_b           (BU_b),
    .twiddle_BU_out (twiddle_BU_out),
    .modulus_BU_out (modulus_BU_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] model_a(input longint x, input longint y,
                                            input longint w, input longint q);
    longint t;
    t = (y * w) % q;
    return DW'((x + t) % q);
  endfunction

  function automatic logic [DW-1:0] model_b(input longint x, input longint y,
                                            input longint w, input longint q);
    longint t;
    t = (y * w) % q;
    return DW'((x - t + q) % q);
  endfunction

  task automatic drive(input logic [DW-1:0] x, input logic [DW-1:0] y,
                       input logic [DW-1:0] w, input logic [DW-1:0] q);
    in1     = x;
    in2     = y;
    twiddle = w;
    modulus = q;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      drive($urandom, $urandom, $urandom, $urandom);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (BU_a !== '0) begin
      tests_failed++;
      $display("FAIL reset_a: got %0d, expected 0", BU_a);
    end
    tests_run++;
    if (BU_b !== '0) begin
      tests_failed++;
      $display("FAIL reset_b: got %0d, expected 0", BU_b);
    end
    tests_run++;
    if (twiddle_BU_out !== '0) begin
      tests_failed++;
      $display("FAIL reset_tw: got %0d, expected 0", twiddle_BU_out);
    end
    tests_run++;
    if (modulus_BU_out !== '0) begin
      tests_failed++;
      $display("FAIL reset_mod: got %0d, expected 0", modulus_BU_out);
    end
    // release and check latency of the first result
    @(negedge clk);
    rst = 1'b0;
    drive(5, 3, 2, Q);
    @(posedge clk);
    #1;
    tests_run++;
    if (modulus_BU_out !== '0) begin
      tests_failed++;
      $display("FAIL release_latency: got %0d after 1 edge, expected 0", modulus_BU_out);
    end
    @(negedge clk);
    drive(0, 0, 0, Q);
    @(posedge clk);
    #1;
    tests_run++;
    if (BU_a !== 32'd11 || BU_b !== 32'd192) begin
      tests_failed++;
      $display("FAIL release_first: got a=%0d b=%0d, expected a=11 b=192", BU_a, BU_b);
    end
    tests_run++;
    if (twiddle_BU_out !== 32'd2 || modulus_BU_out !== Q) begin
      tests_failed++;
      $display("FAIL release_fwd: got tw=%0d mod=%0d, expected tw=2 mod=193",
               twiddle_BU_out, modulus_BU_out);
    end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] vx [0:7];
    logic [DW-1:0] vy [0:7];
    logic [DW-1:0] vw [0:7];
    logic [DW-1:0] ea [0:7];
    logic [DW-1:0] eb [0:7];
    // basic, sum wrap, product reduction, diff wrap, zero twiddle,
    // s = q, x = t, y = 0
    vx = '{5, 190, 100, 0, 42, 100, 50, 17};
    vy = '{3, 10, 192, 1, 77, 93, 50, 0};
    vw = '{2, 1, 192, 192, 0, 1, 1, 99};
    ea = '{11, 7, 101, 192, 42, 0, 100, 17};
    eb = '{192, 180, 99, 1, 42, 7, 0, 17};
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i < 8) drive(vx[i], vy[i], vw[i], Q);
      else drive(0, 0, 0, Q);
      @(posedge clk);
      #1;
      if (i >= 1) begin
        tests_run++;
        if (BU_a !== ea[i-1] || BU_b !== eb[i-1] || twiddle_BU_out !== vw[i-1]) begin
          tests_failed++;
          $display("FAIL directed_%0d: got a=%0d b=%0d tw=%0d, expected a=%0d b=%0d tw=%0d",
                   i - 1, BU_a, BU_b, twiddle_BU_out, ea[i-1], eb[i-1], vw[i-1]);
        end
      end
    end
  endtask

  task automatic test_streaming;
    logic [DW-1:0] sx [0:63];
    logic [DW-1:0] sy [0:63];
    logic [DW-1:0] sw [0:63];
    for (int i = 0; i < 64; i++) begin
      sx[i] = DW'($urandom_range(192, 0));
      sy[i] = DW'($urandom_range(192, 0));
      sw[i] = DW'($urandom_range(192, 0));
    end
    for (int i = 0; i <= 64; i++) begin
      @(negedge clk);
      if (i < 64) drive(sx[i], sy[i], sw[i], Q);
      else drive(0, 0, 0, Q);
      @(posedge clk);
      #1;
      if (i >= 1) begin
        tests_run++;
        if (BU_a !== model_a(sx[i-1], sy[i-1], sw[i-1], Q) ||
            BU_b !== model_b(sx[i-1], sy[i-1], sw[i-1], Q) ||
            twiddle_BU_out !== sw[i-1] || modulus_BU_out !== Q) begin
          tests_failed++;
          $display("FAIL stream_%0d: x=%0d y=%0d w=%0d got a=%0d b=%0d tw=%0d mod=%0d, expected a=%0d b=%0d tw=%0d mod=193",
                   i - 1, sx[i-1], sy[i-1], sw[i-1], BU_a, BU_b, twiddle_BU_out,
                   modulus_BU_out, model_a(sx[i-1], sy[i-1], sw[i-1], Q),
                   model_b(sx[i-1], sy[i-1], sw[i-1], Q), sw[i-1]);
        end
      end
    end
  endtask

  task automatic test_midstream_reset;
    repeat (3) begin
      @(negedge clk);
      drive(DW'($urandom_range(192, 1)), DW'($urandom_range(192, 1)),
            DW'($urandom_range(192, 1)), Q);
      @(posedge clk);
    end
    #1;
    tests_run++;
    if (modulus_BU_out !== Q) begin
      tests_failed++;
      $display("FAIL pre_reset_mod: got %0d, expected 193", modulus_BU_out);
    end
    // assert reset between clock edges: outputs must clear without an edge
    #1;
    rst = 1'b1;
    #1;
    tests_run++;
    if (BU_a !== '0 || BU_b !== '0 || twiddle_BU_out !== '0 || modulus_BU_out !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: got a=%0d b=%0d tw=%0d mod=%0d, expected all 0",
               BU_a, BU_b, twiddle_BU_out, modulus_BU_out);
    end
    @(negedge clk);
    drive(5, 3, 2, Q);
    @(posedge clk);
    #1;
    tests_run++;
    if (BU_a !== '0 || modulus_BU_out !== '0) begin
      tests_failed++;
      $display("FAIL reset_held: got a=%0d mod=%0d, expected 0 0", BU_a, modulus_BU_out);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(190, 10, 1, Q);
    @(posedge clk);
    #1;
    tests_run++;
    if (BU_a !== '0 || modulus_BU_out !== '0) begin
      tests_failed++;
      $display("FAIL reset_flush: got a=%0d mod=%0d, expected 0 0", BU_a, modulus_BU_out);
    end
    @(negedge clk);
    drive(0, 0, 0, Q);
    @(posedge clk);
    #1;
    tests_run++;
    if (BU_a !== 32'd7 || BU_b !== 32'd180 || modulus_BU_out !== Q) begin
      tests_failed++;
      $display("FAIL post_reset: got a=%0d b=%0d mod=%0d, expected a=7 b=180 mod=193",
               BU_a, BU_b, modulus_BU_out);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    drive(0, 0, 0, Q);
    test_reset();
    test_back_to_back();
    test_streaming();
    test_midstream_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
